// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants, pixel type and address widths for the VGA timing path.
package vga_pkg;

  localparam int unsigned H_AW = 10;
  localparam int unsigned V_AW = 10;

  localparam int unsigned DefHSync = 96;
  localparam int unsigned DefHBp   = 48;
  localparam int unsigned DefHAct  = 640;
  localparam int unsigned DefHFp   = 16;
  localparam int unsigned DefVSync = 2;
  localparam int unsigned DefVBp   = 33;
  localparam int unsigned DefVAct  = 480;
  localparam int unsigned DefVFp   = 10;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  // Half-open window test [lo, hi) on a zero-extended counter value.
  function automatic logic in_window(int unsigned pos, int unsigned lo, int unsigned hi);
    return (pos >= lo) && (pos < hi);
  endfunction

endpackage

// File: rtl/vga_delay_line.sv
// Width x Depth shift register with synchronous clear; Depth 0 is a plain wire.
module vga_delay_line #(
  parameter int unsigned Width = 1,
  parameter int unsigned Depth = 1
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic [Width-1:0] d_i,
  output logic [Width-1:0] q_o
);

  if (Depth == 0) begin : g_wire
    logic unused_ctrl;
    assign unused_ctrl = clk_i ^ clr_i;
    assign q_o = d_i;
  end else begin : g_regs
    logic [Width-1:0] stage_q [Depth];
    logic [Width-1:0] stage_d [Depth];

    always_comb begin
      stage_d[0] = d_i;
      for (int unsigned i = 1; i < Depth; i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clk_i) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        if (clr_i) begin
          stage_q[i] <= '0;
        end else begin
          stage_q[i] <= stage_d[i];
        end
      end
    end

    assign q_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_pipe.sv
// VGA timing generator: frame-memory addresses out, pixel data back in, sync/blank delayed to
// line up with the memory read latency and presented on registered pins.
module vga_timing_pipe
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC       = DefHSync,
  parameter int unsigned H_BP         = DefHBp,
  parameter int unsigned H_ACT        = DefHAct,
  parameter int unsigned H_FP         = DefHFp,
  parameter int unsigned V_SYNC       = DefVSync,
  parameter int unsigned V_BP         = DefVBp,
  parameter int unsigned V_ACT        = DefVAct,
  parameter int unsigned V_FP         = DefVFp,
  parameter int unsigned RD_LAT       = 0,
  parameter bit          SYNC_ACT_LOW = 1'b1
) (
  input  logic            pclk,
  input  logic            reset,
  input  logic [23:0]     vga_data,
  output logic [H_AW-1:0] h_addr,
  output logic [V_AW-1:0] v_addr,
  output logic            frame_tick,
  output logic            hsync,
  output logic            vsync,
  output logic            valid,
  output logic [7:0]      vga_r,
  output logic [7:0]      vga_g,
  output logic [7:0]      vga_b
);

  localparam int unsigned HTot   = H_SYNC + H_BP + H_ACT + H_FP;
  localparam int unsigned VTot   = V_SYNC + V_BP + V_ACT + V_FP;
  localparam int unsigned HActLo = H_SYNC + H_BP;
  localparam int unsigned HActHi = HActLo + H_ACT;
  localparam int unsigned VActLo = V_SYNC + V_BP;
  localparam int unsigned VActHi = VActLo + V_ACT;

  if (RD_LAT > 3 || H_ACT == 0 || V_ACT == 0 || HTot == 0 || VTot == 0 ||
      HTot > (1 << H_AW) || VTot > (1 << V_AW)) begin : g_bad_cfg
    $fatal(1, "vga_timing_pipe: unsupported timing configuration");
  end

  logic [H_AW-1:0] hcnt_q, hcnt_d;
  logic [V_AW-1:0] vcnt_q, vcnt_d;
  logic            hs0, vs0, act0;
  logic [2:0]      tap;
  logic            hsync_q, hsync_d;
  logic            vsync_q, vsync_d;
  logic            valid_q, valid_d;
  pixel_t          rgb_q, rgb_d;

  always_comb begin
    hcnt_d = hcnt_q + 1'b1;
    vcnt_d = vcnt_q;
    if (hcnt_q == H_AW'(HTot - 1)) begin
      hcnt_d = '0;
      vcnt_d = (vcnt_q == V_AW'(VTot - 1)) ? '0 : vcnt_q + 1'b1;
    end
  end

  // Stage 0: everything decoded straight from the counters.
  always_comb begin
    hs0        = 32'(hcnt_q) < H_SYNC;
    vs0        = 32'(vcnt_q) < V_SYNC;
    act0       = in_window(32'(hcnt_q), HActLo, HActHi) &&
                 in_window(32'(vcnt_q), VActLo, VActHi);
    h_addr     = act0 ? hcnt_q - H_AW'(HActLo) : '0;
    v_addr     = act0 ? vcnt_q - V_AW'(VActLo) : '0;
    frame_tick = (hcnt_q == '0) && (vcnt_q == '0);
  end

  vga_delay_line #(
    .Width(3),
    .Depth(RD_LAT)
  ) u_ctrl_dly (
    .clk_i(pclk),
    .clr_i(reset),
    .d_i  ({hs0, vs0, act0}),
    .q_o  (tap)
  );

  // Sync taps are active-high internally; polarity is applied only at the pins.
  always_comb begin
    hsync_d = tap[2] ^ SYNC_ACT_LOW;
    vsync_d = tap[1] ^ SYNC_ACT_LOW;
    valid_d = tap[0];
    rgb_d   = tap[0] ? pixel_t'(vga_data) : '0;
  end

  always_ff @(posedge pclk) begin
    if (reset) begin
      hcnt_q  <= '0;
      vcnt_q  <= '0;
      hsync_q <= SYNC_ACT_LOW;
      vsync_q <= SYNC_ACT_LOW;
      valid_q <= 1'b0;
      rgb_q   <= '0;
    end else begin
      hcnt_q  <= hcnt_d;
      vcnt_q  <= vcnt_d;
      hsync_q <= hsync_d;
      vsync_q <= vsync_d;
      valid_q <= valid_d;
      rgb_q   <= rgb_d;
    end
  end

  assign hsync = hsync_q;
  assign vsync = vsync_q;
  assign valid = valid_q;
  assign vga_r = rgb_q.r;
  assign vga_g = rgb_q.g;
  assign vga_b = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_pipe.sv
// Bench for vga_timing_pipe: two scaled-timing instances (RD_LAT 0 and 2) and one 640x480 instance,
// each checked against a reference counter model through a latency-aligned expectation queue.
module tb_vga_timing_pipe;
  import vga_pkg::*;

  localparam int SHS = 4, SHB = 3, SHA = 8, SHF = 2;
  localparam int SVS = 2, SVB = 2, SVA = 5, SVF = 1;
  localparam int SHT = SHS + SHB + SHA + SHF;
  localparam int SVT = SVS + SVB + SVA + SVF;
  localparam int CHT = 800, CVT = 525;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       act;
    logic [9:0] ha;
    logic [9:0] va;
    logic       ft;
  } st0_t;

  typedef struct packed {
    logic        hs_n;
    logic        vs_n;
    logic        vld;
    logic [23:0] rgb;
  } pins_t;

  localparam pins_t Idle = {1'b1, 1'b1, 1'b0, 24'h0};

  logic pclk = 1'b0;
  logic rst  = 1'b1;
  bit   mode_a = 1'b0;
  always #5 pclk = ~pclk;

  logic [9:0]  h_addr_a, v_addr_a, h_addr_b, v_addr_b, h_addr_c, v_addr_c;
  logic        ft_a, ft_b, ft_c, hsync_a, hsync_b, hsync_c, vsync_a, vsync_b, vsync_c;
  logic        valid_a, valid_b, valid_c;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b, r_c, g_c, b_c;
  logic [23:0] data_a, data_b, data_c, mem1_q, mem2_q;

  function automatic logic [23:0] f0(logic [9:0] h, logic [9:0] v);
    return {h[7:0] ^ 8'h3C, v[7:0], h[9:8], v[9:8], 4'h9};
  endfunction

  assign data_a = mode_a ? 24'hFFFFFF : f0(h_addr_a, v_addr_a);
  assign data_c = f0(h_addr_c, v_addr_c);
  always @(posedge pclk) begin
    mem1_q <= {h_addr_b[7:0], v_addr_b[7:0], 8'hA5};
    mem2_q <= mem1_q;
  end
  assign data_b = mem2_q;

  vga_timing_pipe #(
    .H_SYNC(SHS), .H_BP(SHB), .H_ACT(SHA), .H_FP(SHF),
    .V_SYNC(SVS), .V_BP(SVB), .V_ACT(SVA), .V_FP(SVF), .RD_LAT(0), .SYNC_ACT_LOW(1'b1)
  ) u_dut_a (
    .pclk(pclk), .reset(rst), .vga_data(data_a), .h_addr(h_addr_a), .v_addr(v_addr_a),
    .frame_tick(ft_a), .hsync(hsync_a), .vsync(vsync_a), .valid(valid_a),
    .vga_r(r_a), .vga_g(g_a), .vga_b(b_a)
  );

  vga_timing_pipe #(
    .H_SYNC(SHS), .H_BP(SHB), .H_ACT(SHA), .H_FP(SHF),
    .V_SYNC(SVS), .V_BP(SVB), .V_ACT(SVA), .V_FP(SVF), .RD_LAT(2), .SYNC_ACT_LOW(1'b1)
  ) u_dut_b (
    .pclk(pclk), .reset(rst), .vga_data(data_b), .h_addr(h_addr_b), .v_addr(v_addr_b),
    .frame_tick(ft_b), .hsync(hsync_b), .vsync(vsync_b), .valid(valid_b),
    .vga_r(r_b), .vga_g(g_b), .vga_b(b_b)
  );

  vga_timing_pipe u_dut_c (
    .pclk(pclk), .reset(rst), .vga_data(data_c), .h_addr(h_addr_c), .v_addr(v_addr_c),
    .frame_tick(ft_c), .hsync(hsync_c), .vsync(vsync_c), .valid(valid_c),
    .vga_r(r_c), .vga_g(g_c), .vga_b(b_c)
  );

  int n_cmp = 0, n_bad = 0, cyc = 0;
  int ah, av, bh, bv, ch, cv;
  pins_t qa[$], qb[$], qc[$];
  int hfall_c, vfall_c, ft_last_a, ft_last_b, vcnt_a;
  logic hs_prev_c, vs_prev_c;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic st0_t ref_stage0(int h, int v, int hsw, int hbp, int hac,
                                      int vsw, int vbp, int vac);
    st0_t s;
    s.hs  = h < hsw;
    s.vs  = v < vsw;
    s.act = (h >= hsw + hbp) && (h < hsw + hbp + hac) && (v >= vsw + vbp) && (v < vsw + vbp + vac);
    s.ha  = s.act ? 10'(h - hsw - hbp) : 10'd0;
    s.va  = s.act ? 10'(v - vsw - vbp) : 10'd0;
    s.ft  = (h == 0) && (v == 0);
    return s;
  endfunction

  task automatic chk_inst(input string nm, input st0_t s, input pins_t e, input logic [9:0] ha_o,
                          input logic [9:0] va_o, input logic ft_o, input pins_t o);
    chk({nm, "_h_addr"}, 32'(ha_o), 32'(s.ha));
    chk({nm, "_v_addr"}, 32'(va_o), 32'(s.va));
    chk({nm, "_frame_tick"}, 32'(ft_o), 32'(s.ft));
    chk({nm, "_hsync"}, 32'(o.hs_n), 32'(e.hs_n));
    chk({nm, "_vsync"}, 32'(o.vs_n), 32'(e.vs_n));
    chk({nm, "_valid"}, 32'(o.vld), 32'(e.vld));
    chk({nm, "_rgb"}, 32'(o.rgb), 32'(e.rgb));
  endtask

  function automatic void adv(inout int h, inout int v, input int ht, input int vt);
    if (h == ht - 1) begin
      h = 0;
      v = (v == vt - 1) ? 0 : v + 1;
    end else begin
      h = h + 1;
    end
  endfunction

  task automatic tick();
    st0_t  s;
    pins_t e;
    @(posedge pclk);
    if (rst) begin
      ah = 0; av = 0; bh = 0; bv = 0; ch = 0; cv = 0;
      qa.delete(); qb.delete(); qc.delete();
      qa.push_back(Idle);
      repeat (3) qb.push_back(Idle);
      qc.push_back(Idle);
      hfall_c = -1; vfall_c = -1; ft_last_a = -1; ft_last_b = -1; vcnt_a = 0;
      hs_prev_c = 1'b1; vs_prev_c = 1'b1;
    end else begin
      adv(ah, av, SHT, SVT);
      adv(bh, bv, SHT, SVT);
      adv(ch, cv, CHT, CVT);
    end
    @(negedge pclk);
    cyc++;

    s = ref_stage0(ah, av, SHS, SHB, SHA, SVS, SVB, SVA);
    e = qa.pop_front();
    chk_inst("a", s, e, h_addr_a, v_addr_a, ft_a, {hsync_a, vsync_a, valid_a, r_a, g_a, b_a});
    qa.push_back({~s.hs, ~s.vs, s.act, s.act ? (mode_a ? 24'hFFFFFF : f0(s.ha, s.va)) : 24'h0});

    s = ref_stage0(bh, bv, SHS, SHB, SHA, SVS, SVB, SVA);
    e = qb.pop_front();
    chk_inst("b", s, e, h_addr_b, v_addr_b, ft_b, {hsync_b, vsync_b, valid_b, r_b, g_b, b_b});
    qb.push_back({~s.hs, ~s.vs, s.act, s.act ? {s.ha[7:0], s.va[7:0], 8'hA5} : 24'h0});

    s = ref_stage0(ch, cv, 96, 48, 640, 2, 33, 480);
    e = qc.pop_front();
    chk_inst("c", s, e, h_addr_c, v_addr_c, ft_c, {hsync_c, vsync_c, valid_c, r_c, g_c, b_c});
    qc.push_back({~s.hs, ~s.vs, s.act, s.act ? f0(s.ha, s.va) : 24'h0});

    if (!rst) begin
      if (hs_prev_c && !hsync_c) begin
        if (hfall_c >= 0) chk("c_hsync_period", 32'(cyc - hfall_c), 32'd800);
        hfall_c = cyc;
      end
      if (!hs_prev_c && hsync_c && hfall_c >= 0) chk("c_hsync_low", 32'(cyc - hfall_c), 32'd96);
      if (vs_prev_c && !vsync_c) vfall_c = cyc;
      if (!vs_prev_c && vsync_c && vfall_c >= 0) chk("c_vsync_low", 32'(cyc - vfall_c), 32'd1600);
      if (ft_a) begin
        if (ft_last_a >= 0) begin
          chk("a_frame_period", 32'(cyc - ft_last_a), 32'(SHT * SVT));
          chk("a_valid_per_frame", 32'(vcnt_a), 32'(SHA * SVA));
        end
        ft_last_a = cyc;
        vcnt_a    = 0;
      end
      if (valid_a) vcnt_a++;
      if (ft_b) begin
        if (ft_last_b >= 0) chk("b_frame_period", 32'(cyc - ft_last_b), 32'(SHT * SVT));
        ft_last_b = cyc;
      end
    end
    hs_prev_c = hsync_c;
    vs_prev_c = vsync_c;
  endtask

  initial begin
    int t_act, t_vld;
    st0_t sb;

    rst = 1'b1;
    repeat (5) begin
      tick();
      chk("rst_hsync", 32'(hsync_c), 32'd1);
      chk("rst_vsync", 32'(vsync_c), 32'd1);
      chk("rst_valid", 32'(valid_c), 32'd0);
      chk("rst_rgb", 32'({r_c, g_c, b_c}), 32'd0);
    end
    rst = 1'b0;
    chk("post_rst_frame_tick", 32'(ft_c), 32'd1);
    chk("post_rst_h_addr", 32'(h_addr_c), 32'd0);
    chk("post_rst_v_addr", 32'(v_addr_c), 32'd0);

    for (int i = 0; i < 30000 && !(ch == 144 && cv == 35); i++) tick();
    chk("c_reach_first_active", 32'(ch == 144 && cv == 35), 32'd1);
    chk("c_first_h_addr", 32'(h_addr_c), 32'd0);
    chk("c_first_v_addr", 32'(v_addr_c), 32'd0);
    chk("c_valid_before_first", 32'(valid_c), 32'd0);
    tick();
    chk("c_valid_first", 32'(valid_c), 32'd1);
    chk("c_rgb_first", 32'({r_c, g_c, b_c}), 32'(f0(10'd0, 10'd0)));
    repeat (2000) tick();

    // Reset in the middle of an active line with pixels in flight.
    for (int i = 0; i < 400 && !(ah == 9 && av == 6); i++) tick();
    chk("a_reach_mid_frame", 32'(ah == 9 && av == 6), 32'd1);
    rst    = 1'b1;
    mode_a = 1'b1;
    tick();
    chk("mid_rst_valid_a", 32'(valid_a), 32'd0);
    chk("mid_rst_valid_b", 32'(valid_b), 32'd0);
    chk("mid_rst_rgb_a", 32'({r_a, g_a, b_a}), 32'd0);
    chk("mid_rst_h_addr_a", 32'(h_addr_a), 32'd0);
    rst = 1'b0;

    t_act = -1;
    t_vld = -1;
    for (int i = 0; i < 400 && t_vld < 0; i++) begin
      tick();
      sb = ref_stage0(bh, bv, SHS, SHB, SHA, SVS, SVB, SVA);
      if (t_act < 0 && sb.act) t_act = i;
      if (t_vld < 0 && valid_b) t_vld = i;
    end
    chk("b_valid_seen", 32'(t_vld >= 0 && t_act >= 0), 32'd1);
    chk("b_act_to_valid", 32'(t_vld - t_act), 32'd3);
    repeat (1500) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Pixel-clock timing generator for the 640x480@60 display path.
- Produces h_addr/v_addr for the downstream frame memory and takes back 24-bit pixel data.
- Delays sync/blank to match the memory read latency, then drives registered VGA outputs.
- Sits between the frame memory and the board VGA pins, replacing the plain controller in the top level.

Parameters:
- H_SYNC, 96, hsync pulse width in pixel clocks
- H_BP, 48, horizontal back porch
- H_ACT, 640, active pixels per line
- H_FP, 16, horizontal front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BP, 33, vertical back porch
- V_ACT, 480, active lines
- V_FP, 10, vertical front porch
- RD_LAT, 0, frame-memory read latency in cycles (0..3)
- SYNC_ACT_LOW, 1, 1 = sync pulses active-low

Ports:
- pclk  in  1  pixel clock; all logic on rising edge
- reset  in  1  synchronous, active-high reset
- vga_data  in  24  pixel from frame memory {R,G,B}, valid RD_LAT cycles after address
- h_addr  out  10  active-area column 0..639; 0 outside active
- v_addr  out  10  active-area row 0..479; 0 outside active
- frame_tick  out  1  one-cycle pulse at counter origin (hcnt=0, vcnt=0)
- hsync  out  1  horizontal sync, registered, latency-aligned
- vsync  out  1  vertical sync, registered, latency-aligned
- valid  out  1  active-video / blank_n, registered, latency-aligned
- vga_r  out  8  red, 0 when not valid
- vga_g  out  8  green, 0 when not valid
- vga_b  out  8  blue, 0 when not valid

Behaviour:
- Totals: H_TOT = H_SYNC+H_BP+H_ACT+H_FP (800); V_TOT = sum of the V_* parameters (525).
- hcnt (10b) counts 0..H_TOT-1 and wraps to 0.
- vcnt (10b) increments only when hcnt wraps; it wraps from V_TOT-1 to 0 on the same edge that hcnt wraps.
- Line order: sync, back porch, active, front porch.
  - h_act = hcnt in [H_SYNC+H_BP, H_SYNC+H_BP+H_ACT).
  - v_act likewise with the V_* parameters.
  - act0 = h_act & v_act.
  - hs0 = hcnt < H_SYNC; vs0 = vcnt < V_SYNC.
- Stage 0 is combinational from the counters.
  - h_addr = hcnt-(H_SYNC+H_BP) when act0, else 0.
  - v_addr = vcnt-(V_SYNC+V_BP) when act0, else 0.
  - frame_tick = (hcnt==0 && vcnt==0).
- Delay line: {hs0, vs0, act0} pass through RD_LAT registers. RD_LAT=0 means a direct connection.
- Output register, one cycle after the delay-line tap:
  - hsync/vsync = tapped hs/vs, inverted if SYNC_ACT_LOW.
  - valid = tapped act.
  - rgb = vga_data when tapped act, else 0.
- Total latency is RD_LAT+1 pclk cycles from an address being presented to its pixel appearing on the pins, with sync and valid aligned to that pixel.
- Reset, including mid-frame:
  - hcnt=vcnt=0 and all delay registers clear to inactive.
  - Outputs: hsync=vsync=1 (if SYNC_ACT_LOW, else 0), valid=0, rgb=0.
  - h_addr/v_addr=0 and frame_tick=1 follow from the zeroed counters.
  - The first cycle after reset deasserts starts a fresh frame at origin.
- Boundaries:
  - Last active pixel: h_addr=639, v_addr=479.
  - Next cycle: h_addr=0, and valid drops RD_LAT+1 cycles later.
  - The sync period precedes porches, so no address is ever produced in the sync region.
- Elaboration: RD_LAT>3 or any zero active/total parameter is a fatal error.

Decomposition:
- Shared package vga_pkg holds:
  - the 640x480@60 timing constants;
  - the pixel type (24-bit {r,g,b} struct, 8 bits each);
  - the address widths (H_AW=10, V_AW=10).
- One sub-module: vga_delay_line, a parameterised width/depth shift register with a synchronous clear. It is reused for the {hs, vs, act} bus.

Test Plan:
- Assert reset 5 cycles, then release.
  - During reset: hsync=vsync=1, valid=0, rgb=0.
  - First post-reset cycle: frame_tick=1, h_addr=v_addr=0.
- Run with RD_LAT=0 and vga_data driven as a function of the addresses.
  - First active address (hcnt=144, vcnt=35) gives h_addr=0, v_addr=0.
  - valid rises exactly 1 cycle later, rgb = data for (0,0).
- Measure sync widths and periods.
  - hsync low 96 cycles, period 800.
  - vsync low 1600 cycles (2 lines), frame period 420000 cycles.
  - frame_tick spaced 420000 apart.
- Set RD_LAT=2 with a 2-stage registered memory model returning {h_addr[7:0], v_addr[7:0], 8'hA5}.
  - Every valid pixel matches its address.
  - valid asserts 3 cycles after act0.
- Drive vga_data=24'hFFFFFF constantly.
  - rgb=0 in every blanking cycle.
  - Exactly 307200 valid cycles per frame.
- Assert reset for 1 cycle at hcnt=400, vcnt=200.
  - Next cycle counters are 0 and the delay line is inactive: valid=0 and no stale pixels are emitted.
  - The following frame timing is identical to the first frame.
